// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer_if
// Brief    : PLL handshake and per-domain reset bundle of pll_reset_sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface pll_reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  i_pll_locked;
  logic                  i_soft_reset_req;
  logic                  o_pll_reset;
  logic [NUM_STAGES-1:0] o_stage_reset;
  logic                  o_ready;
  logic                  o_heart_bit;
  logic [7:0]            o_retry_count;

  modport master (
    input  i_pll_locked,
    input  i_soft_reset_req,
    output o_pll_reset,
    output o_stage_reset,
    output o_ready,
    output o_heart_bit,
    output o_retry_count
  );

  modport slave (
    output i_pll_locked,
    output i_soft_reset_req,
    input  o_pll_reset,
    input  o_stage_reset,
    input  o_ready,
    input  o_heart_bit,
    input  o_retry_count
  );
endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : Pulses the PLL reset, qualifies lock, then releases ordered domain
//            resets. Define PLL_RESET_SEQ_LOCK_TIMEOUT_EN for WAIT_LOCK retries.
// Revision : 1.0  initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int NUM_STAGES         = 3,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 8,
`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
  parameter int LOCK_TIMEOUT       = 1_000_000,
`endif
  parameter int HEARTBEAT_DIV      = 12_000_000
) (
  input  wire                   i_clk,
  input  wire                   i_reset,
  pll_reset_sequencer_if.master bus
);

  localparam int c_max_a  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int c_cnt_max = (c_max_a > STAGE_GAP) ? c_max_a : STAGE_GAP;
  localparam int c_cnt_w  = $clog2(c_cnt_max + 1);
  localparam int c_hb_w   = $clog2(HEARTBEAT_DIV + 1);

  localparam logic [c_cnt_w-1:0] c_pll_last = c_cnt_w'(PLL_RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_stb_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(STAGE_GAP - 1);
  localparam logic [c_hb_w-1:0]  c_hb_last  = c_hb_w'(HEARTBEAT_DIV - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                r_state, w_state;
  logic [c_cnt_w-1:0]    r_cnt, w_cnt;
  logic                  r_sync1, r_sync2;
  logic                  r_pll_reset, w_pll_reset;
  logic [NUM_STAGES-1:0] r_stage_reset, w_stage_reset;
  logic                  r_ready, w_ready;
  logic                  r_hb, w_hb;
  logic [c_hb_w-1:0]     r_hb_cnt, w_hb_cnt;
  logic                  w_lock_s;
  logic                  w_restart;
  logic [NUM_STAGES-1:0] w_shifted;

`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
  localparam int c_to_w = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(LOCK_TIMEOUT - 1);
  logic [c_to_w-1:0] r_to_cnt, w_to_cnt;
  logic [7:0]        r_retry, w_retry;
  logic              w_timeout;
`endif

  assign w_lock_s = r_sync2;
  // Released stages are the low-order zeros; each release shifts one more zero in.
  assign w_shifted = r_stage_reset << 1;

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_pll_reset   = r_pll_reset;
    w_stage_reset = r_stage_reset;
    w_ready       = r_ready;
    w_hb          = 1'b0;
    w_hb_cnt      = '0;
    w_restart     = 1'b0;
`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
    w_to_cnt      = '0;
    w_retry       = r_retry;
    w_timeout     = 1'b0;
`endif
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == c_pll_last) begin
          w_state     = S_WAIT_LOCK;
          w_cnt       = '0;
          w_pll_reset = 1'b0;
        end else begin
          w_cnt = r_cnt + c_cnt_w'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state = S_STABLE;
          w_cnt   = '0;
        end
`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
        else if (r_to_cnt == c_to_last) begin
          w_timeout = 1'b1;
          w_restart = 1'b1;
        end else begin
          w_to_cnt = r_to_cnt + c_to_w'(1);
        end
`endif
      end
      S_STABLE: begin
        if (!w_lock_s) begin
          w_state = S_WAIT_LOCK;
          w_cnt   = '0;
        end else if (r_cnt == c_stb_last) begin
          w_state       = S_RELEASE;
          w_cnt         = '0;
          w_stage_reset = w_shifted;
          w_ready       = (w_shifted == '0);
        end else begin
          w_cnt = r_cnt + c_cnt_w'(1);
        end
      end
      S_RELEASE: begin
        if (!w_lock_s) begin
          w_restart = 1'b1;
        end else if (r_stage_reset == '0) begin
          w_state = S_RUN;
          w_cnt   = '0;
        end else if (r_cnt == c_gap_last) begin
          w_cnt         = '0;
          w_stage_reset = w_shifted;
          w_ready       = (w_shifted == '0);
        end else begin
          w_cnt = r_cnt + c_cnt_w'(1);
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_restart = 1'b1;
        end else if (r_hb_cnt == c_hb_last) begin
          w_hb     = ~r_hb;
          w_hb_cnt = '0;
        end else begin
          w_hb     = r_hb;
          w_hb_cnt = r_hb_cnt + c_hb_w'(1);
        end
      end
      default: w_restart = 1'b1;
    endcase

    // A soft request overrides whatever the state decided this cycle.
    if (bus.i_soft_reset_req) begin
      w_restart = 1'b1;
    end
    if (w_restart) begin
      w_state       = S_PLL_RST;
      w_cnt         = '0;
      w_pll_reset   = 1'b1;
      w_stage_reset = '1;
      w_ready       = 1'b0;
      w_hb          = 1'b0;
      w_hb_cnt      = '0;
    end
`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
    if (w_timeout && !bus.i_soft_reset_req && (r_retry != 8'hFF)) begin
      w_retry = r_retry + 8'd1;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_state       <= S_PLL_RST;
      r_cnt         <= '0;
      r_pll_reset   <= 1'b1;
      r_stage_reset <= '1;
      r_ready       <= 1'b0;
      r_hb          <= 1'b0;
      r_hb_cnt      <= '0;
`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_retry       <= 8'd0;
`endif
    end else begin
      r_sync1       <= bus.i_pll_locked;
      r_sync2       <= r_sync1;
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_pll_reset   <= w_pll_reset;
      r_stage_reset <= w_stage_reset;
      r_ready       <= w_ready;
      r_hb          <= w_hb;
      r_hb_cnt      <= w_hb_cnt;
`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
      r_to_cnt      <= w_to_cnt;
      r_retry       <= w_retry;
`endif
    end
  end

  assign bus.o_pll_reset   = r_pll_reset;
  assign bus.o_stage_reset = r_stage_reset;
  assign bus.o_ready       = r_ready;
  assign bus.o_heart_bit   = r_hb;
`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
  assign bus.o_retry_count = r_retry;
`else
  assign bus.o_retry_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Brief    : Directed and random stimulus against a phase/elapsed-time model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pll_reset_sequencer;

  localparam int c_ns  = 3;
  localparam int c_pll = 4;
  localparam int c_stb = 8;
  localparam int c_gap = 2;
  localparam int c_to  = 32;
  localparam int c_hb  = 4;

  localparam int P_PLL  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB  = 2;
  localparam int P_REL  = 3;
  localparam int P_RUN  = 4;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  // Model: current phase, cycles spent in it, retry count, lock synchroniser.
  int   m_phase, m_t, m_retry;
  logic m_s1, m_s2;

  pll_reset_sequencer_if #(.NUM_STAGES(c_ns)) bus();

  pll_reset_sequencer #(
    .NUM_STAGES        (c_ns),
    .PLL_RST_CYCLES    (c_pll),
    .LOCK_STABLE_CYCLES(c_stb),
    .STAGE_GAP         (c_gap),
`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
    .LOCK_TIMEOUT      (c_to),
`endif
    .HEARTBEAT_DIV     (c_hb)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_PLL;
    m_t     = 0;
    m_retry = 0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
  endfunction

  function automatic void model_step();
    int   nxt;
    logic tmo;
    nxt = m_phase;
    tmo = 1'b0;
    case (m_phase)
      P_PLL: begin
        if (m_t == c_pll - 1) nxt = P_WAIT;
      end
      P_WAIT: begin
        if (m_s2) nxt = P_STB;
`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
        else if (m_t == c_to - 1) begin
          nxt = P_PLL;
          tmo = 1'b1;
        end
`endif
      end
      P_STB: begin
        if (!m_s2) nxt = P_WAIT;
        else if (m_t == c_stb - 1) nxt = P_REL;
      end
      P_REL: begin
        if (!m_s2) nxt = P_PLL;
        else if (m_t == (c_ns - 1) * c_gap) nxt = P_RUN;
      end
      default: begin
        if (!m_s2) nxt = P_PLL;
      end
    endcase
    if (bus.i_soft_reset_req) begin
      nxt = P_PLL;
      tmo = 1'b0;
    end
    if (tmo && m_retry < 255) m_retry++;
    m_t     = (nxt != m_phase || bus.i_soft_reset_req) ? 0 : m_t + 1;
    m_phase = nxt;
    m_s2    = m_s1;
    m_s1    = bus.i_pll_locked;
  endfunction

  function automatic logic [c_ns-1:0] exp_stage();
    logic [c_ns-1:0] v;
    for (int k = 0; k < c_ns; k++)
      v[k] = !(m_phase == P_RUN || (m_phase == P_REL && m_t >= k * c_gap));
    return v;
  endfunction

  task automatic compare_all();
    chk("pll_reset",   32'(bus.o_pll_reset),   32'(m_phase == P_PLL));
    chk("stage_reset", 32'(bus.o_stage_reset), 32'(exp_stage()));
    chk("ready",       32'(bus.o_ready),
        32'(m_phase == P_RUN || (m_phase == P_REL && m_t >= (c_ns - 1) * c_gap)));
    chk("heart_bit",   32'(bus.o_heart_bit),   (m_phase == P_RUN) ? 32'((m_t / c_hb) % 2) : 32'd0);
    chk("retry_count", 32'(bus.o_retry_count), 32'(m_retry));
  endtask

  task automatic cycle(input logic lk, input logic sr);
    bus.i_pll_locked     = lk;
    bus.i_soft_reset_req = sr;
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic do_reset();
    i_reset              = 1'b1;
    bus.i_soft_reset_req = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    model_reset();
    compare_all();
    i_reset = 1'b0;
  endtask

  task automatic wait_model(input int ph, input int tt, input string tag);
    int n;
    n = 0;
    while (!(m_phase == ph && m_t == tt) && n < 300) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    if (!(m_phase == ph && m_t == tt)) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int   c0, c1, c2, cr, ch, npll, n, lowrem;
    logic lk, sr;
    c0 = -1; c1 = -1; c2 = -1; cr = -1; ch = -1; lowrem = 0;

    // Power-up with lock already high.
    bus.i_pll_locked     = 1'b1;
    bus.i_soft_reset_req = 1'b0;
    do_reset();
    chk("rst_pll_reset", 32'(bus.o_pll_reset),   32'd1);
    chk("rst_stage",     32'(bus.o_stage_reset), 32'd7);
    chk("rst_ready",     32'(bus.o_ready),       32'd0);
    chk("rst_heart",     32'(bus.o_heart_bit),   32'd0);
    chk("rst_retry",     32'(bus.o_retry_count), 32'd0);
    npll = int'(bus.o_pll_reset);
    for (int c = 1; c <= 40; c++) begin
      cycle(1'b1, 1'b0);
      if (bus.o_pll_reset) npll++;
      if (c0 < 0 && !bus.o_stage_reset[0]) c0 = c;
      if (c1 < 0 && !bus.o_stage_reset[1]) c1 = c;
      if (c2 < 0 && !bus.o_stage_reset[2]) c2 = c;
      if (cr < 0 && bus.o_ready) cr = c;
      if (ch < 0 && bus.o_heart_bit) ch = c;
    end
    chk("s1_pll_width",       32'(npll),    32'(c_pll));
    chk("s1_first_release",   32'(c0),      32'(c_pll + 1 + c_stb));
    chk("s1_gap01",           32'(c1 - c0), 32'(c_gap));
    chk("s1_gap12",           32'(c2 - c1), 32'(c_gap));
    chk("s1_ready_with_last", 32'(cr),      32'(c2));
    chk("s1_heart_first",     32'(ch - c2), 32'(1 + c_hb));

    // Lock loss in RUN: two synchroniser cycles plus the registered output.
    n = 0;
    do begin
      cycle(1'b0, 1'b0);
      n++;
    end while (bus.o_stage_reset != '1 && n < 20);
    chk("s3_loss_latency", 32'(n), 32'd3);
    chk("s3_ready_low",    32'(bus.o_ready), 32'd0);
    npll = 0;
    n    = 0;
    while (!bus.o_ready && n < 100) begin
      if (bus.o_pll_reset) npll++;
      cycle(1'b1, 1'b0);
      n++;
    end
    chk("s3_repulse_width", 32'(npll), 32'(c_pll));
    chk("s3_ready_again",   32'(bus.o_ready), 32'd1);

    // One-cycle dropout at stable count 5: sync delay, the STABLE cycle that
    // sees it, one WAIT_LOCK cycle, then a full stable count.
    cycle(1'b1, 1'b1);
    wait_model(P_STB, 5, "s2_reach_stable");
    cycle(1'b0, 1'b0);
    n    = 1;
    npll = 0;
    while (bus.o_stage_reset[0] && n < 100) begin
      if (bus.o_pll_reset) npll++;
      cycle(1'b1, 1'b0);
      n++;
    end
    chk("s2_no_repulse",      32'(npll), 32'd0);
    chk("s2_relock_release",  32'(n),    32'(4 + c_stb));

    wait_model(P_REL, 1, "s4_reach_release");
    cycle(1'b1, 1'b1);
    chk("s4_stage0_reasserted", 32'(bus.o_stage_reset[0]), 32'd1);
    chk("s4_pll_reset",         32'(bus.o_pll_reset),      32'd1);
    n = 0;
    while (!bus.o_ready && n < 100) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    chk("s4_recover", 32'(bus.o_ready), 32'd1);

    for (int i = 0; i < 2500; i++) begin
      if (lowrem > 0) begin
        lk = 1'b0;
        lowrem--;
      end else begin
        lk = 1'b1;
        if ($urandom_range(59, 0) == 0) lowrem = int'($urandom_range(6, 1));
      end
      sr = ($urandom_range(149, 0) == 0);
      cycle(lk, sr);
    end

    // Asynchronous reset in the middle of RELEASE, between clock edges.
    cycle(1'b1, 1'b1);
    wait_model(P_REL, 2, "s6_reach_release");
    #2 i_reset = 1'b1;
    #1;
    chk("s6_async_pll",   32'(bus.o_pll_reset),   32'd1);
    chk("s6_async_stage", 32'(bus.o_stage_reset), 32'd7);
    chk("s6_async_ready", 32'(bus.o_ready),       32'd0);
    chk("s6_async_heart", 32'(bus.o_heart_bit),   32'd0);
    chk("s6_async_retry", 32'(bus.o_retry_count), 32'd0);
    do_reset();
    n = 0;
    while (!bus.o_ready && n < 100) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    chk("s6_recover", 32'(bus.o_ready), 32'd1);

`ifdef PLL_RESET_SEQ_LOCK_TIMEOUT_EN
    begin : b_s5
      int   r1, r2;
      logic prev;
      r1 = -1;
      r2 = -1;
      bus.i_pll_locked = 1'b0;
      do_reset();
      for (int c = 1; c <= 256 * (c_pll + c_to) + 60; c++) begin
        prev = bus.o_pll_reset;
        cycle(1'b0, 1'b0);
        if (!prev && bus.o_pll_reset) begin
          if (r1 < 0) r1 = c;
          else if (r2 < 0) r2 = c;
        end
      end
      chk("s5_repulse_period", 32'(r2 - r1), 32'(c_pll + c_to));
      chk("s5_retry_sat",      32'(bus.o_retry_count), 32'd255);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
